// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES decryption front-end (inv_shift_sub_bytes).
//   STATE_W / BYTE_W / NUM_BYTES : AES state geometry
//   isb_state_t                  : FSM encoding (IDLE / BUSY / DONE)
//   inv_shift_idx(o)             : source byte index for output byte o under
//                                  InvShiftRows (byte i = row i%4, col i/4)
// Optional feature macro used by the top: ISB_PARITY_EN.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } isb_state_t;

    // InvShiftRows moves row r right by r columns, so output column c of row r
    // comes from input column (c - r) mod 4. The 2-bit subtraction wraps for us.
    function automatic logic [3:0] inv_shift_idx(input logic [3:0] o);
        logic [1:0] row;
        logic [1:0] src_col;
        row     = o[1:0];
        src_col = o[3:2] - row;
        return {src_col, row};
    endfunction

endpackage

// File: rtl/sbox_dec.sv
// -----------------------------------------------------------------------------
// sbox_dec
// Combinational AES inverse S-box (InvSubBytes for one byte).
// Ports:
//   cipher_byte  in   8  byte to substitute
//   plain_byte   out  8  InvSBox(cipher_byte)
// -----------------------------------------------------------------------------
module sbox_dec
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] cipher_byte,
    output logic [BYTE_W-1:0] plain_byte
);

    localparam logic [BYTE_W-1:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign plain_byte = INV_SBOX[cipher_byte];

endmodule

// File: rtl/inv_shift_sub_bytes.sv
// -----------------------------------------------------------------------------
// inv_shift_sub_bytes
// Decryption round front-end: InvShiftRows followed by InvSubBytes on one
// 128-bit AES state, LANES bytes per cycle through LANES inverse S-boxes.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The sender holds valid (and data) until that edge; out_valid
// and out_state do not change while out_valid=1 and out_ready=0.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    in_state valid
//   in_ready   out  1    block can accept a state (IDLE only)
//   in_state   in   128  [127:120]=byte0; byte i = row i%4, column i/4
//   out_valid  out  1    out_state valid, held until accepted
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  transformed state, same byte order
//   out_parity out  16   (only with ISB_PARITY_EN) bit i = XOR of out byte i
//
// Parameter LANES: 1, 2, 4, 8 or 16 bytes per cycle.
// Macro ISB_PARITY_EN: adds the registered out_parity port.
// -----------------------------------------------------------------------------
module inv_shift_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
`ifdef ISB_PARITY_EN
    ,
    output logic [NUM_BYTES-1:0] out_parity
`endif
);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_shift_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int         BEATS    = NUM_BYTES / LANES;
    localparam logic [3:0] LAST_CNT = 4'(BEATS - 1);

    isb_state_t state_q;
    isb_state_t state_d;
    logic [3:0] cnt_q;
    // Holds in_ready low through reset and rises on the first edge after it.
    logic       rdy_en_q;
    logic       accept;

    // Index 0 is the MSB byte so byte numbering matches the port layout.
    logic [0:NUM_BYTES-1][BYTE_W-1:0] src_q;
    logic [0:NUM_BYTES-1][BYTE_W-1:0] res_q;

    logic [3:0]        out_idx  [LANES];
    logic [BYTE_W-1:0] lane_in  [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)            state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE: if (out_ready)         state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rdy_en_q && (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
    end

    // ---------------------------------------------------------------- lanes
    // Lane l produces output byte cnt*LANES + l; its source byte is found by
    // undoing the row shift on the captured state.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            out_idx[l] = 4'(int'(cnt_q) * LANES + l);
            lane_in[l] = src_q[inv_shift_idx(out_idx[l])];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_dec u_sbox (
            .cipher_byte (lane_in[g]),
            .plain_byte  (lane_out[g])
        );
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            src_q    <= '0;
            res_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                src_q <= in_state;
                cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                for (int l = 0; l < LANES; l++) begin
                    res_q[out_idx[l]] <= lane_out[l];
                end
                if (cnt_q != LAST_CNT) begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign out_state = res_q;

`ifdef ISB_PARITY_EN
    logic [NUM_BYTES-1:0] parity_q;

    // Parity bits are written alongside their bytes, so they stay in step
    // with out_state, including under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= '0;
        end else if (!accept && state_q == ST_BUSY) begin
            for (int l = 0; l < LANES; l++) begin
                parity_q[out_idx[l]] <= ^lane_out[l];
            end
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
